// File: rtl/bitnet_weight_encoder.sv
// Streaming FP4 E3M0 weight encoder: quantises signed weights to {sign, exp} nibbles and packs LANES per word.
// Optional statistics counters are enabled by defining BITNET_ENC_STATS_EN.

// Combinational magnitude -> log2 nibble encoder with round-half-up on the exponent.
module bitnet_enc_nib #(
  parameter int IN_W = 16
) (
  input  logic [IN_W-1:0] w,
  output logic [3:0]      nib,
  output logic            sat,
  output logic            zero,
  output logic            one
);
  localparam int PW = $clog2(IN_W);
  localparam logic [PW:0] E_MAX = 7;

  logic            s;
  logic [IN_W-1:0] m;
  logic [PW-1:0]   p;
  logic            half;
  logic [PW:0]     e;

  always_comb begin
    s    = w[IN_W-1];
    // most negative input wraps to 2^(IN_W-1), which is the correct unsigned magnitude
    m    = s ? ('0 - w) : w;
    p    = '0;
    for (int i = 0; i < IN_W; i++)
      if (m[i]) p = PW'(i);
    half = (p != '0) ? m[p - PW'(1)] : 1'b0;
    e    = {1'b0, p} + {{PW{1'b0}}, half};
    zero = (m == '0);
    sat  = !zero && (e > E_MAX);
    // +1 has no E3M0 code distinct from zero, so it collapses to zero
    one  = !s && (m == IN_W'(1));
    nib  = (zero || one) ? 4'b0000 : {s, sat ? 3'd7 : e[2:0]};
  end
endmodule

// One packing lane: holds its nibble until the word is handed to the output register.
module bitnet_enc_lane (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [3:0] nib,
  output logic [3:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  q <= 4'b0000;
    else if (clr)  q <= 4'b0000;
    else if (wr)   q <= nib;
endmodule

module bitnet_weight_encoder #(
  parameter  int IN_W  = 16,
  parameter  int LANES = 8,
  localparam int OUT_W = 4*LANES,
  localparam int CNT_W = $clog2(LANES+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last
`ifdef BITNET_ENC_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      sat_cnt,
  output logic [15:0]      zero_cnt,
  output logic [15:0]      one_cnt
`endif
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             last;
  } word_t;

  logic                  accept;
  logic                  complete;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            nib;
  logic                  enc_sat;
  logic                  enc_zero;
  logic                  enc_one;
  logic [LANES-1:0][3:0] lane_q;
  logic [LANES-1:0][3:0] word;
  word_t                 out_q;
  logic                  out_v;

  assign in_ready  = !out_v || out_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (in_last || (idx == IDX_W'(LANES-1)));

  assign out_valid = out_v;
  assign out_data  = out_q.data;
  assign out_count = out_q.count;
  assign out_last  = out_q.last;

  bitnet_enc_nib #(.IN_W(IN_W)) u_enc (
    .w    (in_data),
    .nib  (nib),
    .sat  (enc_sat),
    .zero (enc_zero),
    .one  (enc_one)
  );

  // The completing weight bypasses its lane register straight into the output word.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic sel;
    assign sel = accept && (idx == IDX_W'(k));
    bitnet_enc_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (sel),
      .clr     (complete),
      .nib     (nib),
      .q       (lane_q[k])
    );
    assign word[k] = sel ? nib : lane_q[k];
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)      idx <= '0;
    else if (complete) idx <= '0;
    else if (accept)   idx <= idx + IDX_W'(1);

  // complete implies in_ready, so a pending word is never overwritten
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (complete) begin
      out_v       <= 1'b1;
      out_q.data  <= word;
      out_q.count <= CNT_W'(idx) + CNT_W'(1);
      out_q.last  <= in_last;
    end else if (out_ready) begin
      out_v <= 1'b0;
    end

`ifdef BITNET_ENC_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sat_cnt  <= '0;
      zero_cnt <= '0;
      one_cnt  <= '0;
    end else if (stats_clr) begin
      sat_cnt  <= '0;
      zero_cnt <= '0;
      one_cnt  <= '0;
    end else if (accept) begin
      if (enc_sat  && (sat_cnt  != 16'hFFFF)) sat_cnt  <= sat_cnt  + 16'd1;
      if (enc_zero && (zero_cnt != 16'hFFFF)) zero_cnt <= zero_cnt + 16'd1;
      if (enc_one  && (one_cnt  != 16'hFFFF)) one_cnt  <= one_cnt  + 16'd1;
    end
`else
  logic unused_flags;
  assign unused_flags = ^{enc_sat, enc_zero, enc_one};
`endif

endmodule

// File: tb/tb_bitnet_weight_encoder.sv
// Randomized self-checking bench for bitnet_weight_encoder against a log2-rounding reference model.
// Stats ports are exercised when BITNET_ENC_STATS_EN is defined.
module tb_bitnet_weight_encoder;
  localparam int IN_W  = 16;
  localparam int LANES = 8;
  localparam int OUT_W = 4*LANES;
  localparam int CNT_W = $clog2(LANES+1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_last;
  logic             stats_clr = 1'b0;
  logic [15:0]      sat_cnt, zero_cnt, one_cnt;

  bitnet_weight_encoder #(.IN_W(IN_W), .LANES(LANES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
`ifdef BITNET_ENC_STATS_EN
    ,
    .stats_clr (stats_clr),
    .sat_cnt   (sat_cnt),
    .zero_cnt  (zero_cnt),
    .one_cnt   (one_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exponent = floor(log2 m), bumped when m >= 1.5 * 2^floor.
  function automatic logic [3:0] ref_enc(input int w, output bit sat, output bit zero, output bit one);
    longint m;
    int     e;
    bit     s;
    s = (w < 0);
    m = s ? -longint'(w) : longint'(w);
    sat = 0; zero = 0; one = 0;
    if (m == 0) begin zero = 1; return 4'b0000; end
    e = 0;
    while ((m >> (e+1)) != 0) e++;
    if (2*m >= 3*(longint'(1) << e)) e++;
    if (e > 7) begin sat = 1; e = 7; end
    if (!s && e == 0) begin one = 1; return 4'b0000; end
    return {s, 3'(e)};
  endfunction

  typedef struct {
    logic [OUT_W-1:0] data;
    int               count;
    bit               last;
  } word_t;

  word_t            expq[$];
  logic [OUT_W-1:0] pw = '0;
  int               pc = 0;
  int               m_sat = 0, m_zero = 0, m_one = 0;
  int               ov_cycles = 0;
  int               stalls = 0;
  bit               bp_mode = 0;

  // Scoreboard: check the held output word every cycle, then absorb the accepted weight.
  always @(negedge clk) begin
    if (!reset_n) begin
      expq.delete();
      pw = '0; pc = 0;
      m_sat = 0; m_zero = 0; m_one = 0;
    end else begin
      if (out_valid) begin
        ov_cycles++;
        if (expq.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          chk("out_data", out_data, expq[0].data);
          chk("out_count", out_count, expq[0].count);
          chk("out_last", out_last, expq[0].last);
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (stats_clr) begin m_sat = 0; m_zero = 0; m_one = 0; end
      if (in_valid && in_ready) begin
        bit fs, fz, fo;
        logic [3:0] nb;
        nb = ref_enc(int'($signed(in_data)), fs, fz, fo);
        if (!stats_clr) begin
          if (fs && m_sat  < 65535) m_sat++;
          if (fz && m_zero < 65535) m_zero++;
          if (fo && m_one  < 65535) m_one++;
        end
        pw[4*pc +: 4] = nb;
        pc++;
        if (pc == LANES || in_last) begin
          expq.push_back('{pw, pc, in_last});
          pw = '0; pc = 0;
        end
      end
    end
  end

  task automatic send(input int w, input bit last);
    bit acc;
    int n;
    in_valid = 1'b1; in_data = w[IN_W-1:0]; in_last = last;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (bp_mode) out_ready = ($urandom_range(3) != 0);
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (n > 1) stalls += n - 1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  function automatic int rnd_w();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(1) == 1) begin
      int v = int'($urandom_range(0, 20));
      return ($urandom_range(1) == 1) ? -v : v;
    end
    return int'($signed(r));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  int t1 [8] = '{3, 5, -6, -1, 1, 0, 128, -32768};
  logic [OUT_W-1:0] held;

  initial begin
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_last", out_last, 0);
    reset_n = 1'b1; out_ready = 1'b1;
    step();

    for (int i = 0; i < 8; i++) send(t1[i], 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hF7008B22);
    chk("t1_count", out_count, 8);
    chk("t1_last", out_last, 0);
`ifdef BITNET_ENC_STATS_EN
    chk("t1_sat_cnt", sat_cnt, 1);
    chk("t1_zero_cnt", zero_cnt, 1);
    chk("t1_one_cnt", one_cnt, 1);
`endif

    send(-2, 0); send(4, 0); send(64, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 32'h00000629);
    chk("t2_count", out_count, 3);
    chk("t2_last", out_last, 1);

    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_w(), 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_in_ready_low", in_ready, 0);
    held = out_data;
    step(); step(); step();
    chk("t3_held_data", out_data, held);
    chk("t3_in_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(-(i+3), i == 7);
    step();

    for (int i = 0; i < 5; i++) send(i + 7, 0);
    reset_n = 1'b0; #1;
    chk("t4_valid", out_valid, 0);
    chk("t4_data", out_data, 0);
    chk("t4_count", out_count, 0);
    chk("t4_last", out_last, 0);
    chk("t4_in_ready", in_ready, 1);
    @(negedge clk); step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send(2, 0);
    chk("t4_data_after", out_data, 32'h11111111);
    chk("t4_count_after", out_count, 8);

    send(200, 0); send(96, 0); send(95, 0); send(-32768, 1);
    chk("t5_data", out_data, 32'h0000F677);
    chk("t5_count", out_count, 4);
    chk("t5_last", out_last, 1);
`ifdef BITNET_ENC_STATS_EN
    chk("t5_sat_cnt", sat_cnt, 2);
`endif

    step(); step();
    ov_cycles = 0; stalls = 0;
    for (int i = 0; i < 16; i++) send(rnd_w(), 0);
    chk("t6_stalls", stalls, 0);
    step(); step(); step();
    chk("t6_valid_cycles", ov_cycles, 2);

`ifdef BITNET_ENC_STATS_EN
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    chk("clr_sat_cnt", sat_cnt, 0);
    chk("clr_zero_cnt", zero_cnt, 0);
    chk("clr_one_cnt", one_cnt, 0);
`endif

    bp_mode = 1;
    for (int i = 0; i < 400; i++) send(rnd_w(), $urandom_range(7) == 0);
    send(rnd_w(), 1);
    bp_mode = 0; out_ready = 1'b1;
    step(); step(); step();
    chk("drain_queue_empty", expq.size(), 0);
    chk("drain_partial_empty", pc, 0);
    chk("drain_valid", out_valid, 0);
`ifdef BITNET_ENC_STATS_EN
    chk("rand_sat_cnt", sat_cnt, m_sat);
    chk("rand_zero_cnt", zero_cnt, m_zero);
    chk("rand_one_cnt", one_cnt, m_one);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
